// File: rtl/mem_io_pkg.sv
// Shared types and default region map for the memory-mapped I/O bridge.
package mem_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    FLT_NONE,
    FLT_UNMAPPED,
    FLT_TIMEOUT,
    FLT_CONFLICT
  } fault_e;

  // Slave 0 sits in the low 32 bits; slave 0 is the 1 KiB SRAM at address 0.
  localparam logic [4*32-1:0] DEF_SLV_BASE = {32'h0000_0400, 32'h0000_0440,
                                              32'h0000_0480, 32'h0000_0000};
  localparam logic [4*32-1:0] DEF_SLV_MASK = {32'hFFFF_FFC0, 32'hFFFF_FFC0,
                                              32'hFFFF_FFC0, 32'hFFFF_FC00};

endpackage

// File: rtl/mem_io_decode.sv
// Address-to-slave decoder: one-hot hit on the lowest matching region.
module mem_io_decode
  import mem_io_pkg::*;
#(
  parameter int unsigned                NUM_SLV  = 4,
  parameter int unsigned                ADDR_W   = 32,
  parameter logic [NUM_SLV*ADDR_W-1:0]  SLV_BASE = DEF_SLV_BASE,
  parameter logic [NUM_SLV*ADDR_W-1:0]  SLV_MASK = DEF_SLV_MASK
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [NUM_SLV-1:0] hit,
  output logic               hit_valid
);

  always_comb begin
    hit       = '0;
    hit_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (!hit_valid &&
          ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
        hit[i]    = 1'b1;
        hit_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_io_bridge.sv
// Single-outstanding load/store bridge from the pipeline request FIFO to
// memory-mapped slaves, with decode, ready timeout and fault reporting.
module mem_io_bridge
  import mem_io_pkg::*;
#(
  parameter int unsigned                NUM_SLV  = 4,
  parameter int unsigned                DATA_W   = 32,
  parameter int unsigned                ADDR_W   = 32,
  parameter logic [NUM_SLV*ADDR_W-1:0]  SLV_BASE = DEF_SLV_BASE,
  parameter logic [NUM_SLV*ADDR_W-1:0]  SLV_MASK = DEF_SLV_MASK,
  parameter int unsigned                TIMEOUT  = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      store,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W/8-1:0]       be,
  input  logic                      fifo_empty,
  output logic                      fifo_rd_en,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic                      err,
  output logic [NUM_SLV-1:0]        slv_sel,
  output logic                      slv_we,
  output logic [ADDR_W-1:0]         slv_addr,
  output logic [DATA_W-1:0]         slv_wdata,
  output logic [DATA_W/8-1:0]       slv_be,
  input  logic [NUM_SLV*DATA_W-1:0] slv_rdata,
  input  logic [NUM_SLV-1:0]        slv_ready
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e               state;
  fault_e               fault;
  logic [7:0]           wait_cnt;
  logic [ADDR_W-1:0]    cap_addr;
  logic [DATA_W-1:0]    cap_wdata;
  logic [DATA_W/8-1:0]  cap_be;
  logic                 cap_store;
  logic [NUM_SLV-1:0]   cap_sel;
  logic                 done_first;
  logic [DATA_W-1:0]    rd_data_q;

  logic [NUM_SLV-1:0]   dec_hit;
  logic                 dec_valid;
  logic [DATA_W-1:0]    sel_rdata;
  logic                 sel_ready;

  mem_io_decode #(
    .NUM_SLV  (NUM_SLV),
    .ADDR_W   (ADDR_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .addr      (addr),
    .hit       (dec_hit),
    .hit_valid (dec_valid)
  );

  always_comb begin
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (cap_sel[i]) sel_rdata = sel_rdata | slv_rdata[i*DATA_W +: DATA_W];
    end
  end

  assign sel_ready = |(slv_ready & cap_sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      fault      <= FLT_NONE;
      wait_cnt   <= '0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_be     <= '0;
      cap_store  <= 1'b0;
      cap_sel    <= '0;
      done_first <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      done_first <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load || store) begin
            cap_addr  <= addr;
            cap_wdata <= wdata;
            cap_be    <= be;
            cap_store <= store;
            wait_cnt  <= '0;
            if (load && store) begin
              cap_sel    <= '0;
              fault      <= FLT_CONFLICT;
              done_first <= 1'b1;
              state      <= ST_DONE;
            end else if (!dec_valid) begin
              cap_sel    <= '0;
              fault      <= FLT_UNMAPPED;
              done_first <= 1'b1;
              state      <= ST_DONE;
            end else begin
              cap_sel <= dec_hit;
              fault   <= FLT_NONE;
              state   <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          // Ready in the final counted cycle still wins over the timeout.
          if (sel_ready) begin
            rd_data_q  <= sel_rdata;
            done_first <= 1'b1;
            state      <= ST_DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            fault      <= FLT_TIMEOUT;
            done_first <= 1'b1;
            state      <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          if (!fifo_empty) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign slv_sel    = (state == ST_ACCESS) ? cap_sel : '0;
  assign slv_we     = (state == ST_ACCESS) && cap_store;
  assign slv_addr   = cap_addr;
  assign slv_wdata  = cap_wdata;
  assign slv_be     = cap_be;
  assign err        = done_first && (fault != FLT_NONE);
  assign rd_valid   = done_first && (fault == FLT_NONE) && !cap_store;
  assign rd_data    = rd_valid ? rd_data_q : '0;
  assign fifo_rd_en = (state == ST_DONE) && !fifo_empty;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Randomized transaction bench for mem_io_bridge against a region-map model.
module tb_mem_io_bridge;

  localparam int TIMEOUT = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         load, store;
  logic [31:0]  addr, wdata;
  logic [3:0]   be;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [31:0]  rd_data;
  logic         rd_valid, err;
  logic [3:0]   slv_sel;
  logic         slv_we;
  logic [31:0]  slv_addr, slv_wdata;
  logic [3:0]   slv_be;
  logic [127:0] slv_rdata;
  logic [3:0]   slv_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // Region map: slave index -> base/mask.
  logic [31:0] m_base [4] = '{32'h0000_0000, 32'h0000_0480, 32'h0000_0440, 32'h0000_0400};
  logic [31:0] m_mask [4] = '{32'hFFFF_FC00, 32'hFFFF_FFC0, 32'hFFFF_FFC0, 32'hFFFF_FFC0};

  mem_io_bridge #(
    .NUM_SLV (4),
    .DATA_W  (32),
    .ADDR_W  (32),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .store      (store),
    .addr       (addr),
    .wdata      (wdata),
    .be         (be),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .err        (err),
    .slv_sel    (slv_sel),
    .slv_we     (slv_we),
    .slv_addr   (slv_addr),
    .slv_wdata  (slv_wdata),
    .slv_be     (slv_be),
    .slv_rdata  (slv_rdata),
    .slv_ready  (slv_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_decode(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if ((a & m_mask[i]) == m_base[i]) return i;
    return -1;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, ".sel"},    32'(slv_sel),    32'h0);
    check({tag, ".we"},     32'(slv_we),     32'h0);
    check({tag, ".rvalid"}, 32'(rd_valid),   32'h0);
    check({tag, ".err"},    32'(err),        32'h0);
    check({tag, ".rdata"},  rd_data,         32'h0);
  endtask

  // rdy_lat: ACCESS cycle index at which the selected slave answers (>= TIMEOUT means never).
  task automatic run_txn(input logic ld, input logic st, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] b,
                         input int rdy_lat, input int empty_cyc, input logic [31:0] rdat);
    int          idx;
    bit          mapped, success;
    int          acc;
    logic [3:0]  sel_mask;
    idx      = model_decode(a);
    mapped   = !(ld && st) && (idx >= 0);
    sel_mask = mapped ? 4'(1 << idx) : 4'h0;
    for (int s = 0; s < 4; s++)
      slv_rdata[s*32 +: 32] = (s == idx) ? rdat : $urandom;
    load = ld; store = st; addr = a; wdata = wd; be = b;
    fifo_empty = 1'($urandom);
    @(posedge clk); #1;
    load = 1'b0; store = 1'b0; addr = $urandom; wdata = $urandom; be = 4'($urandom);
    success = 1'b0;
    if (mapped) begin
      acc     = (rdy_lat < TIMEOUT) ? rdy_lat + 1 : TIMEOUT;
      success = (rdy_lat < TIMEOUT);
      for (int k = 0; k < acc; k++) begin
        slv_ready  = 4'($urandom) & ~sel_mask;
        if (k == rdy_lat) slv_ready = slv_ready | sel_mask;
        fifo_empty = 1'b0;
        @(negedge clk);
        check("acc.sel",    32'(slv_sel),   32'(sel_mask));
        check("acc.we",     32'(slv_we),    32'(st));
        check("acc.addr",   slv_addr,       a);
        check("acc.wdata",  slv_wdata,      wd);
        check("acc.be",     32'(slv_be),    32'(b));
        check("acc.fifo",   32'(fifo_rd_en), 32'h0);
        check("acc.rvalid", 32'(rd_valid),  32'h0);
        check("acc.err",    32'(err),       32'h0);
        @(posedge clk); #1;
      end
    end
    slv_ready = '0;
    for (int j = 0; j <= empty_cyc; j++) begin
      fifo_empty = (j < empty_cyc);
      @(negedge clk);
      if (j == 0) begin
        check("done.rvalid", 32'(rd_valid), 32'(success && ld));
        check("done.rdata",  rd_data,       (success && ld) ? rdat : 32'h0);
        check("done.err",    32'(err),      32'(!success));
      end else begin
        check("hold.rvalid", 32'(rd_valid), 32'h0);
        check("hold.err",    32'(err),      32'h0);
      end
      check("done.sel",  32'(slv_sel),    32'h0);
      check("done.we",   32'(slv_we),     32'h0);
      check("done.fifo", 32'(fifo_rd_en), 32'(j == empty_cyc));
      @(posedge clk); #1;
    end
    fifo_empty = 1'($urandom);
    @(negedge clk);
    check_quiet("idle");
    check("idle.fifo", 32'(fifo_rd_en), 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1);
  end

  initial begin
    int          op, pick, lat;
    logic [31:0] a;
    rst = 1'b1; load = 1'b0; store = 1'b0; addr = '0; wdata = '0; be = '0;
    fifo_empty = 1'b0; slv_rdata = '0; slv_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    load = 1'b1; slv_ready = '1;
    @(negedge clk);
    check_quiet("rst");
    check("rst.fifo", 32'(fifo_rd_en), 32'h0);
    check("rst.addr", slv_addr,        32'h0);
    @(posedge clk); #1;
    load = 1'b0; slv_ready = '0; rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    run_txn(1, 0, 32'h0000_0010, 32'h0,         4'hF, 2,    0, 32'h1234_5678);
    run_txn(0, 1, 32'h0000_0440, 32'hA5A5_A5A5, 4'hF, 0,    0, 32'h0);
    run_txn(0, 1, 32'h0000_0480, 32'h5A5A_5A5A, 4'h3, 0,    0, 32'h0);
    run_txn(1, 0, 32'h0000_2000, 32'h0,         4'hF, 0,    0, 32'hDEAD_BEEF);
    run_txn(1, 0, 32'h0000_0440, 32'h0,         4'hF, 1000, 0, 32'hCAFE_0000);
    run_txn(1, 0, 32'h0000_0404, 32'h0,         4'hF, TIMEOUT - 1, 2, 32'h0BAD_F00D);
    run_txn(0, 1, 32'h0000_0444, 32'h1111_2222, 4'hC, 3,    5, 32'h0);
    run_txn(1, 1, 32'h0000_0010, 32'h3333_4444, 4'hF, 0,    1, 32'h7777_7777);

    // Reset in the middle of an access.
    load = 1'b1; addr = 32'h0000_0440;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; fifo_empty = 1'b0; slv_ready = '1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_quiet("mid_rst");
      check("mid_rst.fifo", 32'(fifo_rd_en), 32'h0);
      check("mid_rst.addr", slv_addr,        32'h0);
      @(posedge clk); #1;
    end
    slv_ready = '0;

    // Randomized traffic.
    for (int t = 0; t < 200; t++) begin
      op   = $urandom_range(0, 9);
      pick = $urandom_range(0, 5);
      case (pick)
        0: a = 32'($urandom_range(0, 32'h3FF));
        1: a = 32'h0000_0400 + 32'($urandom_range(0, 63));
        2: a = 32'h0000_0440 + 32'($urandom_range(0, 63));
        3: a = 32'h0000_0480 + 32'($urandom_range(0, 63));
        4: a = 32'h0000_04C0 + 32'($urandom_range(0, 32'h1FF));
        default: a = $urandom;
      endcase
      lat = ($urandom_range(0, 7) == 0) ? 1000 : $urandom_range(0, 20);
      run_txn(op == 0 || (op % 2) == 1, op == 0 || (op % 2) == 0, a, $urandom,
              4'($urandom), lat, $urandom_range(0, 3), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
